// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one UART transmitter between
//               NUM_REQ byte producers, with inter-byte gap and watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 10417,
    parameter int TIMEOUT_CLKS = 12 * CLKS_PER_BIT,
    parameter int GAP_CLKS     = 0
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [NUM_REQ-1:0]         Req,
    input  logic [8*NUM_REQ-1:0]       Req_Byte,
    output logic [NUM_REQ-1:0]         Grant,
    output logic [$clog2(NUM_REQ)-1:0] Last_Grant,
    output logic                       Busy,
    output logic                       Timeout_Err,
    output logic                       Tx_Start,
    output logic [7:0]                 Tx_Byte,
    input  logic                       Tx_Active,
    input  logic                       Tx_Done
);

    localparam int c_LW = $clog2(NUM_REQ);
    localparam int c_TW = $clog2(TIMEOUT_CLKS + 1);
    localparam int c_GW = $clog2(GAP_CLKS + 2);

    localparam logic [c_TW-1:0] c_TO_LAST  = c_TW'(TIMEOUT_CLKS - 1);
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    localparam logic [c_LW-1:0] c_LAST_RST = c_LW'(NUM_REQ - 1);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WAIT_DONE = 2'd1;
    localparam logic [1:0] c_GAP       = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;

    logic [c_TW-1:0]    r_wd_cnt;
    logic [c_TW-1:0]    w_wd_cnt;
    logic [c_GW-1:0]    r_gap_cnt;
    logic [c_GW-1:0]    w_gap_cnt;

    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] w_grant;
    logic               r_tx_start;
    logic               w_tx_start;
    logic [7:0]         r_tx_byte;
    logic [7:0]         w_tx_byte;
    logic [c_LW-1:0]    r_last;
    logic [c_LW-1:0]    w_last;
    logic               r_busy;
    logic               w_busy;
    logic               r_terr;
    logic               w_terr;

    logic               w_pick_vld;
    logic [c_LW-1:0]    w_pick;
    logic               w_arb_win;
    logic               w_timeout;
    logic [7:0]         w_bytes [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_bytes[gi] = Req_Byte[8*gi +: 8];
        end
    endgenerate

    function automatic logic [c_LW-1:0] f_wrap(input logic [c_LW-1:0] base, input int off);
        f_wrap = c_LW'((32'(base) + 32'(off)) % NUM_REQ);
    endfunction

    // Search starts just after the last winner, so the previous winner has lowest priority.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!w_pick_vld && Req[f_wrap(r_last, off)]) begin
                w_pick_vld = 1'b1;
                w_pick     = f_wrap(r_last, off);
            end
        end
    end

    assign w_arb_win = (r_state == c_IDLE) && w_pick_vld && !Tx_Active;
    // Tx_Done takes precedence over an expiring watchdog on the same cycle.
    assign w_timeout = (r_state == c_WAIT_DONE) && !Tx_Done && (r_wd_cnt == c_TO_LAST);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_arb_win) begin
                    w_next_state = c_WAIT_DONE;
                end
            end
            c_WAIT_DONE: begin
                if (Tx_Done) begin
                    w_next_state = (GAP_CLKS > 0) ? c_GAP : c_IDLE;
                end else if (w_timeout) begin
                    w_next_state = c_IDLE;
                end
            end
            c_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_grant    = '0;
        w_tx_start = 1'b0;
        w_tx_byte  = r_tx_byte;
        w_last     = r_last;
        w_terr     = w_timeout;
        // Busy covers everything outside IDLE, so it follows the next state directly.
        w_busy     = (w_next_state != c_IDLE);
        w_wd_cnt   = (r_state == c_WAIT_DONE) ? r_wd_cnt + c_TW'(1) : '0;
        w_gap_cnt  = (r_state == c_GAP) ? r_gap_cnt + c_GW'(1) : '0;
        if (w_arb_win) begin
            w_grant[w_pick] = 1'b1;
            w_tx_start      = 1'b1;
            w_tx_byte       = w_bytes[w_pick];
            w_last          = w_pick;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_grant    <= '0;
            r_tx_start <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_last     <= c_LAST_RST;
            r_busy     <= 1'b0;
            r_terr     <= 1'b0;
            r_wd_cnt   <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_grant    <= w_grant;
            r_tx_start <= w_tx_start;
            r_tx_byte  <= w_tx_byte;
            r_last     <= w_last;
            r_busy     <= w_busy;
            r_terr     <= w_terr;
            r_wd_cnt   <= w_wd_cnt;
            r_gap_cnt  <= w_gap_cnt;
        end
    end

    assign Grant       = r_grant;
    assign Tx_Start    = r_tx_start;
    assign Tx_Byte     = r_tx_byte;
    assign Last_Grant  = r_last;
    assign Busy        = r_busy;
    assign Timeout_Err = r_terr;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Randomized bench with a timestamp-based reference model and a
//               behavioural transmitter stub driving Tx_Active/Tx_Done.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int CLKS_PER_BIT = 16;
    localparam int TIMEOUT_CLKS = 192;
    localparam int GAP_CLKS     = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_byte;
    logic [3:0]  grant;
    logic [1:0]  last_grant;
    logic        busy;
    logic        timeout_err;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_active;
    logic        tx_done;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .TIMEOUT_CLKS (TIMEOUT_CLKS),
        .GAP_CLKS     (GAP_CLKS)
    ) u_dut (
        .Clk         (clk),
        .Rst         (rst),
        .Req         (req),
        .Req_Byte    (req_byte),
        .Grant       (grant),
        .Last_Grant  (last_grant),
        .Busy        (busy),
        .Timeout_Err (timeout_err),
        .Tx_Start    (tx_start),
        .Tx_Byte     (tx_byte),
        .Tx_Active   (tx_active),
        .Tx_Done     (tx_done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: every rule is expressed as edge timestamps.
    bit         mdl_valid = 1'b0;
    bit         inflight  = 1'b0;
    bit         gap_pend  = 1'b0;
    int         g_edge    = 0;
    int         gap_end   = 0;
    int         free_at   = 0;
    logic [3:0] e_grant   = '0;
    logic       e_start   = 1'b0;
    logic       e_busy    = 1'b0;
    logic       e_terr    = 1'b0;
    logic [7:0] e_byte    = '0;
    int         e_last    = NUM_REQ - 1;

    always @(posedge clk) begin
        cyc++;
        e_grant = '0;
        e_start = 1'b0;
        e_terr  = 1'b0;
        if (rst) begin
            e_busy    = 1'b0;
            e_byte    = 8'h00;
            e_last    = NUM_REQ - 1;
            inflight  = 1'b0;
            gap_pend  = 1'b0;
            free_at   = cyc + 1;
            mdl_valid = 1'b1;
        end else if (mdl_valid) begin
            if (inflight) begin
                if (tx_done) begin
                    inflight = 1'b0;
                    if (GAP_CLKS == 0) begin
                        e_busy  = 1'b0;
                        free_at = cyc + 1;
                    end else begin
                        gap_pend = 1'b1;
                        gap_end  = cyc + GAP_CLKS;
                        free_at  = cyc + GAP_CLKS + 1;
                    end
                end else if (cyc - g_edge == TIMEOUT_CLKS) begin
                    inflight = 1'b0;
                    e_busy   = 1'b0;
                    e_terr   = 1'b1;
                    free_at  = cyc + 1;
                end
            end else if (gap_pend) begin
                if (cyc == gap_end) begin
                    gap_pend = 1'b0;
                    e_busy   = 1'b0;
                end
            end else if (cyc >= free_at && !tx_active && req != 4'b0) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int idx;
                    idx = (e_last + k) % NUM_REQ;
                    if (req[idx]) begin
                        e_grant  = 4'b0001 << idx;
                        e_start  = 1'b1;
                        e_byte   = req_byte[8*idx +: 8];
                        e_last   = idx;
                        e_busy   = 1'b1;
                        inflight = 1'b1;
                        g_edge   = cyc;
                        break;
                    end
                end
            end
        end
    end

    int n_dut_starts = 0;
    int n_dut_touts  = 0;

    always @(negedge clk) begin
        if (mdl_valid) begin
            check_eq("grant",       32'(grant),       32'(e_grant));
            check_eq("tx_start",    32'(tx_start),    32'(e_start));
            check_eq("tx_byte",     32'(tx_byte),     32'(e_byte));
            check_eq("last_grant",  32'(last_grant),  e_last);
            check_eq("busy",        32'(busy),        32'(e_busy));
            check_eq("timeout_err", 32'(timeout_err), 32'(e_terr));
            if (tx_start === 1'b1) n_dut_starts++;
            if (timeout_err === 1'b1) n_dut_touts++;
        end
    end

    // Transmitter stub state: frame start edge, Tx_Done edge (-1 = never), Tx_Active end edge.
    int s_g         = 0;
    int s_done_edge = -1;
    int s_act_end   = 0;

    task automatic step(input int p_req, input int p_keep, input int p_wd,
                        input int p_odd, input int p_rst);
        int d;
        if (tx_start === 1'b1) begin
            s_g = cyc;
            d   = $urandom_range(2, 40);
            if ($urandom_range(0, 99) < p_odd) begin
                case ($urandom_range(0, 4))
                    0: d = TIMEOUT_CLKS - 1;
                    1: d = TIMEOUT_CLKS;
                    2: d = TIMEOUT_CLKS + 1;
                    3: d = -1;
                    default: d = 10 * CLKS_PER_BIT;
                endcase
            end
            if (d < 0) begin
                s_done_edge = -1;
                s_act_end   = cyc + $urandom_range(150, 230);
            end else begin
                s_done_edge = cyc + d;
                s_act_end   = s_done_edge;
            end
        end
        tx_done   = (cyc + 1 == s_done_edge);
        tx_active = (cyc + 1 > s_g) && (cyc + 1 < s_act_end);

        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] === 1'b1) begin
                if ($urandom_range(0, 99) < p_keep) begin
                    req[i]            = 1'b1;
                    req_byte[8*i +: 8] = 8'($urandom);
                end else begin
                    req[i] = 1'b0;
                end
            end else if (req[i]) begin
                if ($urandom_range(0, 999) < p_wd) req[i] = 1'b0;
            end else if ($urandom_range(0, 999) < p_req) begin
                req[i]            = 1'b1;
                req_byte[8*i +: 8] = 8'($urandom);
            end
        end

        rst = ($urandom_range(0, 999) < p_rst);
    endtask

    task automatic run_phase(input int ncyc, input int p_req, input int p_keep,
                             input int p_wd, input int p_odd, input int p_rst);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            step(p_req, p_keep, p_wd, p_odd, p_rst);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_byte  = '0;
        tx_active = 1'b0;
        tx_done   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_phase(3000, 50,   30,  5,  0,  0);   // sparse traffic, short frames
        run_phase(3000, 1000, 100, 0,  0,  0);   // every requester held: strict rotation
        run_phase(6000, 30,   40,  5,  40, 0);   // watchdog boundaries and stalled frames
        run_phase(4000, 60,   50,  5,  10, 5);   // resets landing in arbitrary states

        check_eq("traffic_seen", 32'(n_dut_starts > 100), 32'd1);
        check_eq("timeouts_seen", 32'(n_dut_touts > 0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
